// File: rtl/seg7_dual_mux_if.sv
// rtl/seg7_dual_mux_if.sv - digit input and display output bundle for seg7_dual_mux
interface seg7_dual_mux_if;
  logic       in_valid;
  logic [3:0] tens;
  logic [3:0] units;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       dp;

  modport master (output in_valid, tens, units, blank_lz, input seg, an, dp);
  modport slave  (input in_valid, tens, units, blank_lz, output seg, an, dp);
endinterface

// File: rtl/seg7_dual_mux.sv
// rtl/seg7_dual_mux.sv - two-digit multiplexed active-low 7-segment driver
// Latches a BCD tens/units pair and alternates the digits with a blank guard cycle between slots.
module seg7_dual_mux #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  seg7_dual_mux_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] AN_OFF  = 2'b11;

  typedef enum logic {S_UNITS, S_TENS} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          dp_q, dp_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    units_d = units_q;
    seg_d   = SEG_OFF;
    an_d    = AN_OFF;
    dp_d    = 1'b1;

    if (bus.in_valid) begin
      tens_d  = bus.tens;
      units_d = bus.units;
    end

    // Last count of a slot is the anode-off guard that hides the digit switch.
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = (state_q == S_UNITS) ? S_TENS : S_UNITS;
    end else begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        S_UNITS: begin
          an_d  = 2'b10;
          seg_d = decode(units_q);
        end
        default: begin
          if (!(bus.blank_lz && tens_q == 4'd0)) begin
            an_d  = 2'b01;
            seg_d = decode(tens_q);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_UNITS;
      cnt_q   <= '0;
      tens_q  <= '0;
      units_q <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.dp  = dp_q;

endmodule
